accel_cmd_issuer: RTL and testbench
===================================

Name: accel_cmd_issuer

Overview:
Host-side initiator for the accelerator control FSM. It takes one layer descriptor from the control/CPU side and launches the layer: one Enable pulse, then the 5-word configuration burst on databus with busrdwr. It then paces weight delivery with one DVAL pulse per 16-input MAC chunk and tracks add_done/neuron_done back from the accelerator. Sits between the host register file / DRAM-ready logic and the accelerator.

Parameters:
PE_SIZE, 16, inputs consumed per MAC chunk; must match the accelerator PE count (power of 2).
TIMEOUT, 1024, max cycles waiting for add_done after a DVAL before error abort.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  launch request; sampled only in IDLE
base_in_addr  in  16  input-activation base address
weight_addr  in  16  weight base address
out_addr  in  16  output base address, sent unmodified (accelerator subtracts 1 itself)
n_in  in  16  total input neurons
n_out  in  16  total output neurons
dram_ready  in  1  weight chunk available; DVAL is only issued while high
add_done  in  1  accelerator chunk-complete pulse
neuron_done  in  1  accelerator neuron-complete pulse
Enable  out  1  one-cycle launch pulse to accelerator
databus  out  16  configuration word
busrdwr  out  1  configuration word valid
DVAL  out  1  one-cycle chunk-start pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: layer complete
err  out  1  one-cycle pulse: descriptor rejected, protocol mismatch, or timeout
neuron_cnt  out  10  output neurons completed in the current layer

Behaviour:
- Reset: all outputs 0, databus 0, state IDLE, all counters 0. Reset mid-layer aborts immediately with no done/err pulse.
- All outputs are registered.
- IDLE, start=1: latch all descriptor fields.
  - Reject if n_in==0, n_in mod PE_SIZE != 0, n_out==0 or n_out>1023: err=1 next cycle, remain IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle): Enable=1 → SEND.
- SEND (exactly 5 cycles, busrdwr=1 every cycle). Words in order: base_in_addr, weight_addr, out_addr, n_in, n_out. The first word is on the bus the cycle immediately after Enable. No gaps; busrdwr drops with the last word → ISSUE.
- ISSUE: when dram_ready=1, DVAL=1 for one cycle → WAIT_ADD. While dram_ready=0, hold.
- WAIT_ADD: wait for add_done.
  - Increment wdog every cycle; when wdog reaches TIMEOUT: err, → IDLE.
  - On add_done: chunk_cnt++ (chunk_cnt is 12 bits) → CHECK.
  - neuron_done seen in WAIT_ADD: err, → IDLE.
- CHECK (1 cycle, the cycle after add_done): compare against last = (chunk_cnt == n_in/PE_SIZE).
  - last and neuron_done=1: chunk_cnt=0, neuron_cnt++. If neuron_cnt+1==n_out: done=1 → IDLE; else → ISSUE.
  - last != neuron_done: err → IDLE.
  - not last and neuron_done=0: → ISSUE.
- DVAL spacing: DVAL is never issued earlier than the cycle after CHECK, so it is ≥2 cycles after add_done.
- start outside IDLE is ignored. neuron_cnt holds its final value after done until the next accepted start, which clears it.
- n_in/PE_SIZE is a shift. n_in up to 16'hFFF0 gives at most 4095 chunks.

Test Plan:
- Reset, then start with base=0x0100, wt=0x2000, out=0x0400, n_in=32, n_out=2, dram_ready=1 → Enable at cycle T; busrdwr T+1..T+5 carrying 0x0100, 0x2000, 0x0400, 0x0020, 0x0002; DVAL at T+6.
- Same layer; answer each DVAL with add_done 8 cycles later, and neuron_done the cycle after every 2nd add_done → 4 DVALs total, neuron_cnt 1 then 2, done pulse once, busy falls with done.
- n_in=24 (not multiple of 16), and separately n_out=0 → err one cycle after start; no Enable, busy stays 0.
- dram_ready held 0 for 20 cycles in ISSUE → no DVAL; DVAL exactly one cycle after dram_ready rises.
- Withhold add_done after a DVAL → err exactly TIMEOUT cycles later, return to IDLE; then a new start relaunches cleanly.
- n_in=16, n_out=3: drop neuron_done after the 2nd add_done → err in CHECK, neuron_cnt=1; separately assert rst mid-SEND → busrdwr 0 next cycle and no done/err pulse.

Source files
------------

// File: rtl/accel_cmd_issuer.sv
// Host-side launcher for the accelerator: sends the 5-word layer descriptor burst, then
// paces one DVAL per PE_SIZE-input chunk and tracks add_done/neuron_done responses.
module accel_cmd_issuer #(
  parameter int PE_SIZE = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_in_addr,
  input  logic [15:0] weight_addr,
  input  logic [15:0] out_addr,
  input  logic [15:0] n_in,
  input  logic [15:0] n_out,
  input  logic        dram_ready,
  input  logic        add_done,
  input  logic        neuron_done,
  output logic        Enable,
  output logic [15:0] databus,
  output logic        busrdwr,
  output logic        DVAL,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  neuron_cnt
);

  localparam int SHIFT = $clog2(PE_SIZE);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] PE_MASK = 16'(PE_SIZE - 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, SEND, ISSUE, WAIT_ADD, CHECK} state_t;

  state_t state, state_n;
  logic [15:0] base_q, weight_q, out_q, n_in_q, n_out_q;
  logic [2:0] word_idx, word_idx_n;
  logic [WDW-1:0] wdog, wdog_n;
  logic [11:0] chunk_cnt, chunk_cnt_n;
  logic [9:0] neuron_n;
  logic [15:0] databus_n, chunk_total;
  logic enable_n, busrdwr_n, dval_n, done_n, err_n;
  logic latch, go_issue, last, bad_desc;

  assign chunk_total = n_in_q >> SHIFT;
  assign last = ({4'd0, chunk_cnt} == chunk_total);
  assign bad_desc = (n_in == 16'd0) || ((n_in & PE_MASK) != 16'd0) ||
                    (n_out == 16'd0) || (n_out > 16'd1023);

  // Next state and next output values; every output is registered below, so a DVAL
  // decision made on the edge leaving SEND/CHECK/ISSUE shows up in the following cycle.
  always_comb begin
    state_n     = state;
    word_idx_n  = word_idx;
    wdog_n      = wdog;
    chunk_cnt_n = chunk_cnt;
    neuron_n    = neuron_cnt;
    databus_n   = 16'd0;
    enable_n    = 1'b0;
    busrdwr_n   = 1'b0;
    dval_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    latch       = 1'b0;
    go_issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (bad_desc) begin
            err_n = 1'b1;
          end else begin
            state_n     = LAUNCH;
            enable_n    = 1'b1;
            neuron_n    = 10'd0;
            chunk_cnt_n = 12'd0;
          end
        end
      end
      LAUNCH: begin
        state_n    = SEND;
        word_idx_n = 3'd0;
        busrdwr_n  = 1'b1;
        databus_n  = base_q;
      end
      SEND: begin
        word_idx_n = word_idx + 3'd1;
        busrdwr_n  = 1'b1;
        case (word_idx)
          3'd0:    databus_n = weight_q;
          3'd1:    databus_n = out_q;
          3'd2:    databus_n = n_in_q;
          3'd3:    databus_n = n_out_q;
          default: begin
            busrdwr_n = 1'b0;
            go_issue  = 1'b1;
          end
        endcase
      end
      ISSUE: go_issue = 1'b1;
      WAIT_ADD: begin
        if (neuron_done) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (add_done) begin
          chunk_cnt_n = chunk_cnt + 12'd1;
          state_n     = CHECK;
        end else if (wdog == WDOG_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      CHECK: begin
        if (last && neuron_done) begin
          chunk_cnt_n = 12'd0;
          neuron_n    = neuron_cnt + 10'd1;
          if (({6'd0, neuron_cnt} + 16'd1) == n_out_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            go_issue = 1'b1;
          end
        end else if (last != neuron_done) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          go_issue = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (go_issue) begin
      if (dram_ready) begin
        state_n = WAIT_ADD;
        dval_n  = 1'b1;
        wdog_n  = '0;
      end else begin
        state_n = ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= 16'd0;
      weight_q   <= 16'd0;
      out_q      <= 16'd0;
      n_in_q     <= 16'd0;
      n_out_q    <= 16'd0;
      word_idx   <= 3'd0;
      wdog       <= '0;
      chunk_cnt  <= 12'd0;
      neuron_cnt <= 10'd0;
      Enable     <= 1'b0;
      databus    <= 16'd0;
      busrdwr    <= 1'b0;
      DVAL       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      word_idx   <= word_idx_n;
      wdog       <= wdog_n;
      chunk_cnt  <= chunk_cnt_n;
      neuron_cnt <= neuron_n;
      Enable     <= enable_n;
      databus    <= databus_n;
      busrdwr    <= busrdwr_n;
      DVAL       <= dval_n;
      busy       <= (state_n != IDLE);
      done       <= done_n;
      err        <= err_n;
      if (latch) begin
        base_q   <= base_in_addr;
        weight_q <= weight_addr;
        out_q    <= out_addr;
        n_in_q   <= n_in;
        n_out_q  <= n_out;
      end
    end
  end

endmodule

// File: tb/tb_accel_cmd_issuer.sv
// Randomized and directed bench for accel_cmd_issuer with a behavioural accelerator
// responder and a layer-level expectation model.
module tb_accel_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start;
  logic [15:0] base_in_addr, weight_addr, out_addr, n_in, n_out;
  logic        dram_ready = 1'b0;
  logic        add_done = 1'b0;
  logic        neuron_done = 1'b0;
  logic        Enable, busrdwr, DVAL, busy, done, err;
  logic [15:0] databus;
  logic [9:0]  neuron_cnt;

  accel_cmd_issuer #(.PE_SIZE(16), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_in_addr(base_in_addr), .weight_addr(weight_addr), .out_addr(out_addr),
    .n_in(n_in), .n_out(n_out), .dram_ready(dram_ready),
    .add_done(add_done), .neuron_done(neuron_done),
    .Enable(Enable), .databus(databus), .busrdwr(busrdwr), .DVAL(DVAL),
    .busy(busy), .done(done), .err(err), .neuron_cnt(neuron_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fails = 0;

  // responder controls, written only by the main sequence
  logic dr_force = 1'b0;
  logic dr_rand = 1'b0;
  logic withhold = 1'b0;
  int   drop_at = 0;
  int   lat_fixed = 8;
  int   chunks_per = 1;

  // monitor records
  int en_n, en_t, dval_n, dval_first_t, done_n, done_t, err_n, err_t;
  int viol, last_add_t, rise_t, busrdwr_last_t, busy_hi;
  logic busy_at_done, busy_prev_at_done, busy_prev, dram_prev;
  logic [9:0] nc_prev;
  logic [15:0] wq[$];
  int tq[$];
  int ncq[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accelerator stand-in: answers each DVAL with add_done after a latency, and every
  // chunks_per-th add_done with neuron_done the following cycle (except the dropped one).
  int cd = 0;
  int add_count = 0;
  logic pend = 1'b0;
  always @(posedge clk) begin
    #1;
    add_done = 1'b0;
    neuron_done = 1'b0;
    dram_ready = dr_rand ? ($urandom_range(0, 3) != 0) : dr_force;
    if (rst) begin
      cd = 0;
      pend = 1'b0;
      add_count = 0;
    end else begin
      if (Enable) add_count = 0;
      if (pend) begin
        neuron_done = 1'b1;
        pend = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          add_done = 1'b1;
          add_count++;
          if ((add_count % chunks_per) == 0 && add_count != drop_at) pend = 1'b1;
        end
      end
      if (DVAL && !withhold) cd = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 12));
    end
  end

  always @(negedge clk) begin
    if (Enable === 1'b1) begin
      en_n++;
      en_t = cyc;
    end
    if (busrdwr === 1'b1) begin
      wq.push_back(databus);
      tq.push_back(cyc);
      busrdwr_last_t = cyc;
    end
    if (busy === 1'b1) busy_hi++;
    if (add_done) last_add_t = cyc;
    if (DVAL === 1'b1) begin
      if (dval_n == 0) dval_first_t = cyc;
      dval_n++;
      if (!dram_prev || (cyc - last_add_t) < 2) viol++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_t = cyc;
      busy_at_done = busy;
      busy_prev_at_done = busy_prev;
    end
    if (err === 1'b1) begin
      err_n++;
      err_t = cyc;
    end
    if (neuron_cnt !== nc_prev) begin
      ncq.push_back(int'(neuron_cnt));
      nc_prev = neuron_cnt;
    end
    if (dram_ready && !dram_prev) rise_t = cyc;
    dram_prev = dram_ready;
    busy_prev = busy;
  end

  task automatic clearMon();
    en_n = 0; en_t = -1; dval_n = 0; dval_first_t = -1; done_n = 0; done_t = -1;
    err_n = 0; err_t = -1; viol = 0; last_add_t = -100; rise_t = -1;
    busrdwr_last_t = -1; busy_hi = 0;
    wq.delete(); tq.delete(); ncq.delete();
    nc_prev = neuron_cnt;
  endtask

  task automatic applyStimulus(input logic [15:0] b, input logic [15:0] w, input logic [15:0] o,
                               input logic [15:0] ni, input logic [15:0] no, output int s);
    @(posedge clk); #1;
    base_in_addr = b; weight_addr = w; out_addr = o; n_in = ni; n_out = no;
    chunks_per = (ni >= 16) ? int'(ni) / 16 : 1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitLayerEnd(input int budget);
    int k = 0;
    while (done_n == 0 && err_n == 0 && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (done_n == 0 && err_n == 0) checkOutput("layer_end_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic checkWords(input string tag, input logic [15:0] b, input logic [15:0] w,
                            input logic [15:0] o, input logic [15:0] ni, input logic [15:0] no,
                            input int t);
    logic [15:0] exp_w[5];
    exp_w[0] = b; exp_w[1] = w; exp_w[2] = o; exp_w[3] = ni; exp_w[4] = no;
    checkOutput({tag, "_nwords"}, wq.size(), 5);
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      checkOutput($sformatf("%s_word%0d", tag, i), wq[i], exp_w[i]);
      checkOutput($sformatf("%s_wcyc%0d", tag, i), tq[i], t + 1 + i);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int s;
    int nin, nout, kind;
    bit valid;
    start = 1'b0;
    base_in_addr = '0; weight_addr = '0; out_addr = '0; n_in = '0; n_out = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_ctrl", {Enable, busrdwr, DVAL, busy, done, err}, 0);
    checkOutput("reset_databus", databus, 0);
    checkOutput("reset_neuron_cnt", neuron_cnt, 0);

    $display("[TB] directed layer n_in=32 n_out=2");
    @(negedge clk) dr_force = 1'b1;
    repeat (2) @(posedge clk);
    #1 clearMon();
    applyStimulus(16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd2, s);
    waitLayerEnd(500);
    checkOutput("dir_enable_cnt", en_n, 1);
    checkOutput("dir_enable_cyc", en_t, s + 1);
    checkWords("dir", 16'h0100, 16'h2000, 16'h0400, 16'h0020, 16'h0002, s + 1);
    checkOutput("dir_first_dval", dval_first_t, s + 7);
    checkOutput("dir_dval_cnt", dval_n, 4);
    checkOutput("dir_nc_steps", ncq.size(), 2);
    if (ncq.size() >= 2) begin
      checkOutput("dir_nc_first", ncq[0], 1);
      checkOutput("dir_nc_second", ncq[1], 2);
    end
    checkOutput("dir_done_cnt", done_n, 1);
    checkOutput("dir_done_cyc", done_t, last_add_t + 2);
    checkOutput("dir_busy_at_done", busy_at_done, 0);
    checkOutput("dir_busy_before_done", busy_prev_at_done, 1);
    checkOutput("dir_err_cnt", err_n, 0);
    checkOutput("dir_dval_rules", viol, 0);

    $display("[TB] rejected descriptors");
    clearMon();
    applyStimulus(16'h0010, 16'h0020, 16'h0030, 16'd24, 16'd1, s);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rej_nin_err_cnt", err_n, 1);
    checkOutput("rej_nin_err_cyc", err_t, s + 1);
    checkOutput("rej_nin_enable", en_n, 0);
    checkOutput("rej_nin_busy", busy_hi, 0);
    clearMon();
    applyStimulus(16'h0010, 16'h0020, 16'h0030, 16'd32, 16'd0, s);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rej_nout_err_cyc", err_t, s + 1);
    checkOutput("rej_nout_enable", en_n, 0);
    checkOutput("rej_nout_busy", busy_hi, 0);

    $display("[TB] dram_ready held low");
    @(negedge clk) dr_force = 1'b0;
    @(posedge clk); #1 clearMon();
    applyStimulus(16'h1111, 16'h2222, 16'h3333, 16'd16, 16'd1, s);
    repeat (26) @(posedge clk);
    #1;
    checkOutput("hold_no_dval", dval_n, 0);
    @(negedge clk) dr_force = 1'b1;
    waitLayerEnd(200);
    checkOutput("hold_dval_after_rise", dval_first_t, rise_t + 1);
    checkOutput("hold_done", done_n, 1);

    $display("[TB] add_done timeout");
    withhold = 1'b1;
    clearMon();
    applyStimulus(16'h0001, 16'h0002, 16'h0003, 16'd16, 16'd1, s);
    waitLayerEnd(1300);
    checkOutput("to_err_cnt", err_n, 1);
    checkOutput("to_err_cyc", err_t, dval_first_t + 1024);
    checkOutput("to_done_cnt", done_n, 0);
    checkOutput("to_busy_after", busy, 0);
    withhold = 1'b0;
    clearMon();
    applyStimulus(16'h0A00, 16'h0B00, 16'h0C00, 16'd48, 16'd2, s);
    waitLayerEnd(800);
    checkOutput("relaunch_done", done_n, 1);
    checkOutput("relaunch_err", err_n, 0);
    checkOutput("relaunch_dval_cnt", dval_n, 6);
    checkOutput("relaunch_neuron_cnt", neuron_cnt, 2);

    $display("[TB] missing neuron_done");
    drop_at = 2;
    clearMon();
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 16'd16, 16'd3, s);
    waitLayerEnd(300);
    checkOutput("drop_err_cnt", err_n, 1);
    checkOutput("drop_done_cnt", done_n, 0);
    checkOutput("drop_neuron_cnt", neuron_cnt, 1);
    drop_at = 0;

    $display("[TB] reset during configuration burst");
    clearMon();
    applyStimulus(16'h0F00, 16'h0E00, 16'h0D00, 16'd32, 16'd1, s);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("rstmid_last_busrdwr", busrdwr_last_t, s + 3);
    checkOutput("rstmid_done", done_n, 0);
    checkOutput("rstmid_err", err_n, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_neuron_cnt", neuron_cnt, 0);

    $display("[TB] randomized layers");
    dr_rand = 1'b1;
    lat_fixed = 0;
    for (int it = 0; it < 10; it++) begin
      logic [15:0] b, w, o;
      b = 16'($urandom); w = 16'($urandom); o = 16'($urandom);
      nin = 16 * int'($urandom_range(1, 4));
      nout = int'($urandom_range(1, 4));
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0: nin = nin + int'($urandom_range(1, 15));
          1: nin = 0;
          2: nout = 0;
          default: nout = 1024 + int'($urandom_range(0, 100));
        endcase
      end
      valid = (nin != 0) && (nin % 16 == 0) && (nout != 0) && (nout <= 1023);
      clearMon();
      applyStimulus(b, w, o, 16'(nin), 16'(nout), s);
      if (valid) begin
        waitLayerEnd(4000);
        checkOutput($sformatf("rnd%0d_enable_cyc", it), en_t, s + 1);
        checkWords($sformatf("rnd%0d", it), b, w, o, 16'(nin), 16'(nout), s + 1);
        checkOutput($sformatf("rnd%0d_dval_cnt", it), dval_n, (nin / 16) * nout);
        checkOutput($sformatf("rnd%0d_done", it), done_n, 1);
        checkOutput($sformatf("rnd%0d_err", it), err_n, 0);
        checkOutput($sformatf("rnd%0d_done_cyc", it), done_t, last_add_t + 2);
        checkOutput($sformatf("rnd%0d_neuron_cnt", it), neuron_cnt, nout);
        checkOutput($sformatf("rnd%0d_dval_rules", it), viol, 0);
      end else begin
        repeat (4) @(posedge clk);
        #1;
        checkOutput($sformatf("rnd%0d_rej_err_cyc", it), err_t, s + 1);
        checkOutput($sformatf("rnd%0d_rej_enable", it), en_n, 0);
        checkOutput($sformatf("rnd%0d_rej_busy", it), busy_hi, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
